// File: rtl/instr_encoder.sv
// RV32I instruction encoder that streams encoded words into an instruction memory.
// It fills the memory from address 0 until the last instruction arrives, a clear is applied, or the memory is full.
module instr_encoder #(
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_fmt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [6:0]        in_funct7,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              done,
    output logic              err
);

    typedef enum logic [3:0] {
        FMT_R     = 4'd0,
        FMT_I     = 4'd1,
        FMT_LOAD  = 4'd2,
        FMT_S     = 4'd3,
        FMT_B     = 4'd4,
        FMT_JAL   = 4'd5,
        FMT_JALR  = 4'd6,
        FMT_LUI   = 4'd7,
        FMT_AUIPC = 4'd8
    } fmt_e;

    typedef enum logic {
        ST_LOAD,
        ST_DONE
    } state_e;

    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] ONE_C   = (ADDR_W+1)'(1);

    state_e            state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic [31:0] enc_word;
    logic        illegal;
    logic        accept;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        enc_word = '0;
        illegal  = 1'b0;
        case (in_fmt)
            FMT_R:     enc_word = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, 7'd51};
            FMT_I: begin
                if (in_funct3 == 3'b001 || in_funct3 == 3'b101)
                    enc_word = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, 7'd19};
                else
                    enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'd19};
            end
            FMT_LOAD:  enc_word = {in_imm[11:0], in_rs1, in_funct3, in_rd, 7'd3};
            FMT_S:     enc_word = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], 7'd35};
            FMT_B: begin
                enc_word = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                            in_imm[4:1], in_imm[11], 7'd99};
                illegal  = in_imm[0];
            end
            FMT_JAL: begin
                enc_word = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, 7'd111};
                illegal  = in_imm[0];
            end
            FMT_JALR:  enc_word = {in_imm[11:0], in_rs1, 3'b000, in_rd, 7'd103};
            FMT_LUI:   enc_word = {in_imm[31:12], in_rd, 7'd55};
            FMT_AUIPC: enc_word = {in_imm[31:12], in_rd, 7'd23};
            default:   illegal  = 1'b1;
        endcase
    end

    assign in_ready = (state_q == ST_LOAD) && (count_q < DEPTH_C);
    assign accept   = in_valid && in_ready;

    // Clear wins over a simultaneous request; rejected words still consume in_last.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        err_d   = err_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (clear) begin
            state_d = ST_LOAD;
            count_d = '0;
            err_d   = 1'b0;
            addr_d  = '0;
            wdata_d = '0;
        end else if (accept) begin
            if (illegal) begin
                err_d = 1'b1;
            end else begin
                we_d    = 1'b1;
                addr_d  = count_q[ADDR_W-1:0];
                wdata_d = enc_word;
                count_d = count_q + ONE_C;
            end
            if (in_last)
                state_d = ST_DONE;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q <= ST_LOAD;
            count_q <= '0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            err_q   <= err_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign count      = count_q;
    assign done       = (state_q == ST_DONE);
    assign err        = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder (DEPTH=4): expected writes go into a scoreboard
// queue when a request is driven and are popped when imem_we appears.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        rst, clear, in_valid, in_ready, in_last;
    logic [3:0]  in_fmt;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [6:0]  in_funct7;
    logic [31:0] in_imm;
    logic        imem_we;
    logic [1:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic [2:0]  count;
    logic        done, err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] data;
    } wr_t;
    wr_t sb_q[$];

    instr_encoder #(.DEPTH(4), .ADDR_W(2)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm), .in_last(in_last),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .count(count), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
            $error("check %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every write must match the oldest expected entry.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            check("write_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                wr_t e;
                e = sb_q.pop_front();
                check("wr_addr", 32'(imem_addr), 32'(e.addr));
                check("wr_data", imem_wdata, e.data);
            end
        end
    end

    // Called just after a falling edge; returns just after the next falling edge.
    task automatic send(input string tag, input logic [3:0] fmt, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm, input logic last,
                        input logic exp_rdy, input logic exp_wr, input logic [1:0] exp_addr,
                        input logic [31:0] exp_data);
        in_valid  = 1'b1;
        in_fmt    = fmt;
        in_rd     = rd;
        in_rs1    = rs1;
        in_rs2    = rs2;
        in_funct3 = f3;
        in_funct7 = f7;
        in_imm    = imm;
        in_last   = last;
        check({tag, "_ready"}, 32'(in_ready), 32'(exp_rdy));
        if (exp_wr)
            sb_q.push_back('{addr: exp_addr, data: exp_data});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_clear(input logic with_req);
        in_valid  = with_req;
        in_fmt    = 4'd1;
        in_rd     = 5'd1;
        in_rs1    = 5'd0;
        in_funct3 = 3'd0;
        in_imm    = 32'd5;
        in_last   = 1'b0;
        clear     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_fmt = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
        in_funct3 = '0; in_funct7 = '0; in_imm = '0;
        repeat (3) @(negedge clk);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;

        // Single I-ALU: write appears one cycle after acceptance, for one cycle.
        send("addi", 4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, 1'b1, 1'b1, 2'd0, 32'h0050_0093);
        check("addi_we", 32'(imem_we), 32'd1);
        check("addi_count", 32'(count), 32'd1);
        idle();
        check("addi_we_once", 32'(imem_we), 32'd0);

        // Back-to-back R then S; rd on S is not part of the S word.
        do_clear(1'b0);
        check("clr_count", 32'(count), 32'd0);
        send("r", 4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0, 1'b1, 1'b1, 2'd0, 32'h0020_81B3);
        check("r_we", 32'(imem_we), 32'd1);
        send("s", 4'd3, 5'd31, 5'd1, 5'd2, 3'd2, 7'h7F, 32'd8, 1'b0, 1'b1, 1'b1, 2'd1, 32'h0020_A423);
        check("s_we", 32'(imem_we), 32'd1);
        check("s_addr", 32'(imem_addr), 32'd1);
        idle();
        check("s_we_done", 32'(imem_we), 32'd0);
        check("rs_count", 32'(count), 32'd2);

        // B / JAL / LUI / AUIPC with junk in unused fields, filling the memory.
        do_clear(1'b0);
        send("b", 4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'h55, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b1, 2'd0, 32'hFE20_8EE3);
        send("jal", 4'd5, 5'd1, 5'd7, 5'd7, 3'd7, 7'h7F, 32'd8, 1'b0, 1'b1, 1'b1, 2'd1, 32'h0080_00EF);
        send("lui", 4'd7, 5'd5, 5'd9, 5'd9, 3'd7, 7'h7F, 32'h1234_5000, 1'b0, 1'b1, 1'b1, 2'd2, 32'h1234_52B7);
        send("auipc", 4'd8, 5'd1, 5'd3, 5'd4, 3'd1, 7'h01, 32'h0000_1000, 1'b0, 1'b1, 1'b1, 2'd3, 32'h0000_1097);
        check("full_count", 32'(count), 32'd4);
        check("full_ready", 32'(in_ready), 32'd0);
        send("over", 4'd0, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
        idle();
        check("over_count", 32'(count), 32'd4);
        check("over_err", 32'(err), 32'd0);
        check("over_done", 32'(done), 32'd0);

        // Five LOADs held valid: only four fit.
        do_clear(1'b0);
        check("clr_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < 5; i++) begin
            logic [31:0] exp_w;
            exp_w = (32'(i * 4) << 20) | (32'd2 << 12) | (32'(i + 1) << 7) | 32'd3;
            send("lw", 4'd2, 5'(i + 1), 5'd0, 5'd0, 3'd2, 7'd0, 32'(i * 4), 1'b0,
                 (i < 4), (i < 4), 2'(i), exp_w);
        end
        idle();
        idle();
        check("lw_count", 32'(count), 32'd4);
        check("lw_ready", 32'(in_ready), 32'd0);
        check("lw_err", 32'(err), 32'd0);
        do_clear(1'b0);
        check("lw_clr_ready", 32'(in_ready), 32'd1);
        check("lw_clr_count", 32'(count), 32'd0);

        // Illegal format and odd branch offset: no write, sticky error.
        send("fmt12", 4'd12, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd4, 1'b0, 1'b1, 1'b0, 2'd0, 32'd0);
        check("fmt12_we", 32'(imem_we), 32'd0);
        check("fmt12_err", 32'(err), 32'd1);
        check("fmt12_count", 32'(count), 32'd0);
        send("bodd", 4'd4, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 1'b0, 1'b1, 1'b0, 2'd0, 32'd0);
        check("bodd_we", 32'(imem_we), 32'd0);
        check("bodd_count", 32'(count), 32'd0);
        send("jalr", 4'd6, 5'd1, 5'd5, 5'd9, 3'd7, 7'h7F, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 2'd0, 32'hFFF2_80E7);
        check("jalr_we", 32'(imem_we), 32'd1);
        check("jalr_err", 32'(err), 32'd1);
        check("jalr_count", 32'(count), 32'd1);
        idle();

        // Last instruction -> DONE; clear with a simultaneous request drops it.
        do_clear(1'b0);
        check("clr_err", 32'(err), 32'd0);
        send("srai", 4'd1, 5'd2, 5'd1, 5'd0, 3'd5, 7'h20, 32'd3, 1'b1, 1'b1, 1'b1, 2'd0, 32'h4030_D113);
        check("last_done", 32'(done), 32'd1);
        check("last_ready", 32'(in_ready), 32'd0);
        send("after_last", 4'd0, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 1'b0, 1'b0, 1'b0, 2'd0, 32'd0);
        check("after_last_done", 32'(done), 32'd1);
        check("after_last_count", 32'(count), 32'd1);
        do_clear(1'b1);
        check("clrreq_we", 32'(imem_we), 32'd0);
        check("clrreq_done", 32'(done), 32'd0);
        check("clrreq_count", 32'(count), 32'd0);
        check("clrreq_ready", 32'(in_ready), 32'd1);

        // Reset coinciding with an acceptance: no write, count back to zero.
        send("pre_rst", 4'd1, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0, 1'b1, 1'b1, 2'd0, 32'h0050_0093);
        in_valid = 1'b1;
        in_fmt   = 4'd0;
        rst      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        check("rstacc_we", 32'(imem_we), 32'd0);
        check("rstacc_count", 32'(count), 32'd0);

        // Illegal request still honours in_last.
        send("ill_last", 4'd9, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0);
        check("ill_last_done", 32'(done), 32'd1);
        check("ill_last_err", 32'(err), 32'd1);
        check("ill_last_count", 32'(count), 32'd0);
        check("ill_last_we", 32'(imem_we), 32'd0);
        idle();
        idle();
        check("sb_drained", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning instruction-memory depth in 32-bit words (power of two, >=2).
REQ-002 SHALL have parameter ADDR_W, default 8, meaning word-address width, equal to log2(DEPTH).
REQ-003 SHALL have port clk  in  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-005 SHALL have port clear  in  1  synchronous restart of the load session.
REQ-006 SHALL have port in_valid  in  1  request carries a valid instruction.
REQ-007 SHALL have port in_ready  out  1  encoder accepts the request this cycle.
REQ-008 SHALL have port in_fmt  in  4  format: 0 R, 1 I-ALU, 2 LOAD, 3 S, 4 B, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC; 9-15 illegal.
REQ-009 SHALL have ports in_rd, in_rs1, in_rs2  in  5 each  register fields.
REQ-010 SHALL have ports in_funct3 (in, 3) and in_funct7 (in, 7)  function fields.
REQ-011 SHALL have port in_imm  in  32  immediate as a signed byte value; U formats carry the full 32-bit value.
REQ-012 SHALL have port in_last  in  1  marks the final instruction of the program.
REQ-013 SHALL have ports imem_we (out, 1), imem_addr (out, ADDR_W), imem_wdata (out, 32)  instruction-memory write port.
REQ-014 SHALL have ports count (out, ADDR_W+1), done (out, 1), err (out, 1)  status.

Function
REQ-015 SHALL emit opcodes R=51, I-ALU=19, LOAD=3, S=35, B=99, JAL=111, JALR=103, LUI=55, AUIPC=23.
REQ-016 SHALL place fields per RV32I: rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], funct7[31:25].
REQ-017 SHALL encode I/LOAD/JALR with imm[11:0] in [31:20]; for I-ALU funct3 001/101, [31:25]=in_funct7 and [24:20]=imm[4:0].
REQ-018 SHALL encode S as imm[11:5] in [31:25] and imm[4:0] in [11:7].
REQ-019 SHALL encode B as imm[12|10:5] in [31:25] and imm[4:1|11] in [11:7].
REQ-020 SHALL encode JAL as imm[20|10:1|11|19:12] in [31:12]; LUI/AUIPC as imm[31:12] in [31:12].
REQ-021 SHALL force funct3=000 for JALR and zero the fields a format does not use.
REQ-022 SHALL treat a request as accepted when in_valid and in_ready are both high at a rising edge.
REQ-023 SHALL assert imem_we for exactly one cycle, the cycle after acceptance, with imem_addr = write pointer and imem_wdata = encoded word (latency 1, throughput 1/cycle).
REQ-024 SHALL increment the write pointer and count at each legal acceptance; the pointer wraps only via clear/rst, never by counting.
REQ-025 SHALL drive in_ready = 1 only in state LOAD and while count < DEPTH.
REQ-026 SHALL implement states LOAD and DONE; LOAD->DONE on acceptance with in_last=1; DONE->LOAD only on clear.
REQ-027 SHALL hold done high in state DONE.
REQ-028 SHALL treat an illegal in_fmt, or B/JAL with imm[0]=1, as an accepted request: no write, no count change, err set sticky; in_last still takes effect.
REQ-029 SHALL give clear priority over a simultaneous request: the request is dropped; pointer, count, err and done are zeroed; state goes to LOAD.
REQ-030 SHALL, when count = DEPTH, hold in_ready low until clear, with no write and no error.

Reset
REQ-031 SHALL on rst set state LOAD, pointer 0, count 0, imem_we 0, imem_addr 0, imem_wdata 0, done 0, err 0.
REQ-032 SHALL on rst mid-operation cancel any pending write; imem_we is 0 in the cycle after the reset edge.

Verification
REQ-033 SHALL verify: I-ALU rd=1 rs1=0 f3=0 imm=5 accepted at cycle N -> imem_we=1 at N+1, addr 0, data 0x00500093, count 1.
REQ-034 SHALL verify back-to-back: R rd=3 rs1=1 rs2=2 then S rs1=1 rs2=2 f3=010 imm=8 -> 0x002081B3 at addr 0, 0x0020A423 at addr 1 on consecutive cycles.
REQ-035 SHALL verify: B rs1=1 rs2=2 f3=0 imm=-4 -> 0xFE208EE3; JAL rd=1 imm=8 -> 0x008000EF; LUI rd=5 imm=0x12345000 -> 0x123452B7.
REQ-036 SHALL verify: DEPTH=4 with 5 requests held valid -> 4 writes (addr 0-3), count=4, in_ready low; clear -> in_ready high, count 0.
REQ-037 SHALL verify: in_fmt=12, then B with imm=3 -> no imem_we, err=1, count unchanged; a following legal request writes normally with err still 1.
REQ-038 SHALL verify: in_last=1 accepted -> done=1 and in_ready=0 from the next cycle; clear and in_valid together -> no write, done=0; rst in the cycle of an acceptance -> no write.
